// File: rtl/ibex_l2_rf_arbiter.sv
// ----------------------------------------------------------------------------
// ibex_l2_rf_arbiter
//
// Shares the single-port, 32-entry L2 register file between NumReq
// requesters (for example the core spill/fill path and the debug module).
// Only one transaction is in flight at a time. Requesters are granted in
// round-robin order, and this block applies the x0 rules itself: writes to x0
// are acknowledged but never reach the register file, and reads of x0 return 0.
//
// Handshake semantics (both channels):
//   A transfer happens in a cycle where valid and ready are both high.
//   - Request channel: the requester raises req_valid_i[i]. The arbiter
//     raises req_ready_o[i] combinationally in the cycle it grants, and only
//     in IDLE. Address, write enable and write data are sampled in that
//     cycle only. Before the grant, valid may come and go freely.
//   - Response channel: the arbiter holds rsp_valid_o[owner] and
//     rsp_rdata_o stable until rsp_ready_i[owner] is high. The rsp_ready_i
//     bits of other requesters are ignored.
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   req_valid_i/ready_o per-requester request handshake
//   req_we_i            per-requester 1 = write, 0 = read
//   req_addr_i          per-requester register index
//   req_wdata_i         per-requester write data
//   rsp_valid_o/ready_i per-requester response handshake
//   rsp_rdata_o         shared response data; 0 when no response is valid
//   rf_addr_o           register file address
//   rf_wdata_o          register file write data
//   rf_we_o             register file write enable
//   rf_rdata_i          register file read data, one cycle after the address
//   busy_o              a transaction is in flight (state is not IDLE)
//
// The FSM state is held in state_q so that checkers can bind to it directly.
// ----------------------------------------------------------------------------
module ibex_l2_rf_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned DataWidth = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq-1:0]                req_we_i,
    input  logic [NumReq-1:0][4:0]           req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0] req_wdata_i,
    output logic [NumReq-1:0]                rsp_valid_o,
    input  logic [NumReq-1:0]                rsp_ready_i,
    output logic [DataWidth-1:0]             rsp_rdata_o,
    output logic [4:0]                       rf_addr_o,
    output logic [DataWidth-1:0]             rf_wdata_o,
    output logic                             rf_we_o,
    input  logic [DataWidth-1:0]             rf_rdata_i,
    output logic                             busy_o
);

    localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef logic [PtrW-1:0] ptr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RSP     = 2'd2
    } state_e;

    state_e               state_q, state_d;
    ptr_t                 rr_ptr_q, rr_ptr_d;
    ptr_t                 owner_q, owner_d;
    logic [4:0]           addr_q, addr_d;
    logic [DataWidth-1:0] rsp_q, rsp_d;

    // ------------------------------------------------------------------------
    // Round-robin pick: scan from rr_ptr_q upward, wrapping at NumReq. The
    // wrap is done by subtraction so NumReq need not be a power of two.
    // ------------------------------------------------------------------------
    logic        gnt_found;
    ptr_t        gnt_idx;
    int unsigned scan_idx;
    ptr_t        scan_ptr;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        scan_ptr  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            scan_idx = 32'(rr_ptr_q) + i;
            if (scan_idx >= NumReq) begin
                scan_idx = scan_idx - NumReq;
            end
            scan_ptr = ptr_t'(scan_idx);
            if (!gnt_found && req_valid_i[scan_ptr]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_ptr;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        rsp_d       = rsp_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        rf_addr_o   = '0;
        rf_wdata_o  = '0;
        rf_we_o     = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    owner_d              = gnt_idx;
                    rr_ptr_d             = (gnt_idx == ptr_t'(NumReq - 1)) ? '0
                                                                           : ptr_t'(gnt_idx + 1'b1);
                    addr_d               = req_addr_i[gnt_idx];
                    rf_addr_o            = req_addr_i[gnt_idx];
                    if (req_we_i[gnt_idx]) begin
                        // The write is issued in the grant cycle itself, so
                        // write data never needs to be registered. x0 is
                        // acknowledged but never written.
                        rf_wdata_o = req_wdata_i[gnt_idx];
                        rf_we_o    = (req_addr_i[gnt_idx] != 5'd0);
                        rsp_d      = '0;
                        state_d    = RSP;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                // The register file's read data is valid now. It is not
                // refreshed for x0, so the arbiter substitutes zero itself.
                rf_addr_o = addr_q;
                rsp_d     = (addr_q == 5'd0) ? '0 : rf_rdata_i;
                state_d   = RSP;
            end

            RSP: begin
                rsp_valid_o[owner_q] = 1'b1;
                rsp_rdata_o          = rsp_q;
                if (rsp_ready_i[owner_q]) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers. Reset drops any in-flight transaction without a
    // response; a write already pulsed to the register file stays committed.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            addr_q   <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            rsp_q    <= rsp_d;
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_l2_rf_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for ibex_l2_rf_arbiter. It uses two instances: NumReq=2, backed by
// a behavioural register file, and NumReq=4, used for the wrap-around case.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// later, before the next rising edge.
// ----------------------------------------------------------------------------
module tb_ibex_l2_rf_arbiter;

    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- NumReq = 2 instance ----------------
    logic [1:0]          d_valid, d_ready, d_we, d_rsp_valid, d_rsp_ready;
    logic [1:0][4:0]     d_addr;
    logic [1:0][DW-1:0]  d_wdata;
    logic [DW-1:0]       d_rsp_rdata, d_rf_wdata, d_rf_rdata;
    logic [4:0]          d_rf_addr;
    logic                d_rf_we, d_busy;

    ibex_l2_rf_arbiter #(.NumReq(2), .DataWidth(DW)) u_dut2 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (d_valid),
        .req_ready_o (d_ready),
        .req_we_i    (d_we),
        .req_addr_i  (d_addr),
        .req_wdata_i (d_wdata),
        .rsp_valid_o (d_rsp_valid),
        .rsp_ready_i (d_rsp_ready),
        .rsp_rdata_o (d_rsp_rdata),
        .rf_addr_o   (d_rf_addr),
        .rf_wdata_o  (d_rf_wdata),
        .rf_we_o     (d_rf_we),
        .rf_rdata_i  (d_rf_rdata),
        .busy_o      (d_busy)
    );

    // Register file model: registered read, and read data is held (not
    // refreshed) when x0 is addressed. Reset only preloads a few entries and
    // leaves non-zero stale read data, so a missing x0 override is visible.
    logic [DW-1:0] rf_mem [32];
    always @(posedge clk) begin
        if (rst) begin
            rf_mem[1]  <= 32'h1111_1111;
            rf_mem[2]  <= 32'h2222_2222;
            d_rf_rdata <= 32'hBAD0_BAD0;
        end else begin
            if (d_rf_we) rf_mem[d_rf_addr] <= d_rf_wdata;
            if (d_rf_addr != 5'd0) d_rf_rdata <= rf_mem[d_rf_addr];
        end
    end

    // ---------------- NumReq = 4 instance ----------------
    logic [3:0]          q_valid, q_ready, q_we, q_rsp_valid, q_rsp_ready;
    logic [3:0][4:0]     q_addr;
    logic [3:0][DW-1:0]  q_wdata;
    logic [DW-1:0]       q_rsp_rdata, q_rf_wdata;
    logic [DW-1:0]       q_rf_rdata = '0;
    logic [4:0]          q_rf_addr;
    logic                q_rf_we, q_busy;

    ibex_l2_rf_arbiter #(.NumReq(4), .DataWidth(DW)) u_dut4 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (q_valid),
        .req_ready_o (q_ready),
        .req_we_i    (q_we),
        .req_addr_i  (q_addr),
        .req_wdata_i (q_wdata),
        .rsp_valid_o (q_rsp_valid),
        .rsp_ready_i (q_rsp_ready),
        .rsp_rdata_o (q_rsp_rdata),
        .rf_addr_o   (q_rf_addr),
        .rf_wdata_o  (q_rf_wdata),
        .rf_we_o     (q_rf_we),
        .rf_rdata_i  (q_rf_rdata),
        .busy_o      (q_busy)
    );

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        d_valid = '0; d_we = '0; d_addr = '0; d_wdata = '0; d_rsp_ready = '0;
        q_valid = '0; q_we = '0; q_addr = '0; q_wdata = '0; q_rsp_ready = '0;
    endtask

    // On return, the bench is at a falling edge with reset released.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (d_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got=%b exp=00", d_ready); end
        checks++; if (d_rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=00", d_rsp_valid); end
        checks++; if (d_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata got=%h exp=0", d_rsp_rdata); end
        checks++; if (d_rf_addr !== 5'd0) begin errors++; $display("FAIL rst_rf_addr got=%0d exp=0", d_rf_addr); end
        checks++; if (d_rf_wdata !== 32'h0) begin errors++; $display("FAIL rst_rf_wdata got=%h exp=0", d_rf_wdata); end
        checks++; if (d_rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we got=%b exp=0", d_rf_we); end
        checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", d_busy); end
        checks++; if ({q_busy, q_ready} !== 5'b0) begin errors++; $display("FAIL rst_q4_idle got=%b exp=00000", {q_busy, q_ready}); end
    endtask

    task automatic test_write_read();
        apply_reset();
        d_rsp_ready = 2'b11;
        d_valid = 2'b01; d_we = 2'b01; d_addr[0] = 5'd5; d_wdata[0] = 32'hDEAD_BEEF;
        #1;
        checks++; if (d_ready !== 2'b01) begin errors++; $display("FAIL wr_grant got=%b exp=01", d_ready); end
        checks++; if (d_rf_we !== 1'b1) begin errors++; $display("FAIL wr_rf_we got=%b exp=1", d_rf_we); end
        checks++; if (d_rf_addr !== 5'd5) begin errors++; $display("FAIL wr_rf_addr got=%0d exp=5", d_rf_addr); end
        checks++; if (d_rf_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rf_wdata got=%h exp=deadbeef", d_rf_wdata); end
        @(negedge clk);
        d_valid = 2'b00;
        #1;
        checks++; if (d_rsp_valid !== 2'b01) begin errors++; $display("FAIL wr_ack_valid got=%b exp=01", d_rsp_valid); end
        checks++; if (d_rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_ack_rdata got=%h exp=0", d_rsp_rdata); end
        checks++; if (d_rf_we !== 1'b0) begin errors++; $display("FAIL wr_we_one_cycle got=%b exp=0", d_rf_we); end
        checks++; if (d_ready !== 2'b00) begin errors++; $display("FAIL wr_no_grant_in_rsp got=%b exp=00", d_ready); end
        @(negedge clk);
        d_valid = 2'b01; d_we = 2'b00; d_addr[0] = 5'd5;
        #1;
        checks++; if (d_ready !== 2'b01) begin errors++; $display("FAIL rd_grant got=%b exp=01", d_ready); end
        checks++; if ({d_rf_we, d_rf_addr} !== {1'b0, 5'd5}) begin errors++; $display("FAIL rd_issue got=%b/%0d exp=0/5", d_rf_we, d_rf_addr); end
        @(negedge clk);
        d_valid = 2'b00;
        #1;
        checks++; if ({d_busy, d_rsp_valid} !== 3'b100) begin errors++; $display("FAIL rd_wait got=%b exp=100", {d_busy, d_rsp_valid}); end
        checks++; if (d_rf_addr !== 5'd5) begin errors++; $display("FAIL rd_wait_addr got=%0d exp=5", d_rf_addr); end
        @(negedge clk);
        #1;
        checks++; if (d_rsp_valid !== 2'b01) begin errors++; $display("FAIL rd_rsp_valid got=%b exp=01", d_rsp_valid); end
        checks++; if (d_rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rsp_rdata got=%h exp=deadbeef", d_rsp_rdata); end
        @(negedge clk);
        #1;
        checks++; if ({d_busy, d_rsp_rdata} !== 33'h0) begin errors++; $display("FAIL rd_done got=%b/%h exp=0/0", d_busy, d_rsp_rdata); end
    endtask

    task automatic test_x0();
        apply_reset();
        d_rsp_ready = 2'b11;
        d_valid = 2'b01; d_we = 2'b01; d_addr[0] = 5'd0; d_wdata[0] = 32'h0000_1234;
        #1;
        checks++; if (d_ready !== 2'b01) begin errors++; $display("FAIL x0_wr_grant got=%b exp=01", d_ready); end
        checks++; if (d_rf_we !== 1'b0) begin errors++; $display("FAIL x0_wr_we got=%b exp=0", d_rf_we); end
        @(negedge clk);
        d_valid = 2'b00;
        #1;
        checks++; if ({d_rsp_valid, d_rsp_rdata} !== {2'b01, 32'h0}) begin errors++; $display("FAIL x0_wr_ack got=%b/%h exp=01/0", d_rsp_valid, d_rsp_rdata); end
        @(negedge clk);
        d_valid = 2'b01; d_we = 2'b00; d_addr[0] = 5'd0;
        #1;
        checks++; if ({d_ready, d_rf_we} !== 3'b010) begin errors++; $display("FAIL x0_rd_grant got=%b exp=010", {d_ready, d_rf_we}); end
        @(negedge clk);
        d_valid = 2'b00;
        @(negedge clk);
        #1;
        checks++; if (d_rsp_valid !== 2'b01) begin errors++; $display("FAIL x0_rd_valid got=%b exp=01", d_rsp_valid); end
        checks++; if (d_rsp_rdata !== 32'h0) begin errors++; $display("FAIL x0_rd_rdata got=%h exp=0", d_rsp_rdata); end
    endtask

    task automatic test_round_robin();
        logic [1:0]    exp_rdy;
        logic [DW-1:0] exp_data;
        apply_reset();
        d_rsp_ready = 2'b11;
        d_valid = 2'b11; d_we = 2'b00; d_addr[0] = 5'd1; d_addr[1] = 5'd2;
        for (int g = 0; g < 4; g++) begin
            exp_rdy  = (g % 2 == 0) ? 2'b01 : 2'b10;
            exp_data = (g % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
            if (g > 0) @(negedge clk);
            #1;
            checks++; if (d_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", g, d_ready, exp_rdy); end
            @(negedge clk);
            #1;
            checks++; if ({d_busy, d_ready} !== 3'b100) begin errors++; $display("FAIL rr_wait%0d got=%b exp=100", g, {d_busy, d_ready}); end
            @(negedge clk);
            #1;
            checks++; if (d_rsp_valid !== exp_rdy) begin errors++; $display("FAIL rr_rsp%0d got=%b exp=%b", g, d_rsp_valid, exp_rdy); end
            checks++; if (d_rsp_rdata !== exp_data) begin errors++; $display("FAIL rr_data%0d got=%h exp=%h", g, d_rsp_rdata, exp_data); end
        end
        d_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        apply_reset();
        d_rsp_ready = 2'b01;   // only the non-owner is ready
        d_valid = 2'b10; d_we = 2'b00; d_addr[1] = 5'd2; d_addr[0] = 5'd1;
        #1;
        checks++; if (d_ready !== 2'b10) begin errors++; $display("FAIL bp_grant got=%b exp=10", d_ready); end
        @(negedge clk);
        d_valid = 2'b01;       // req0 waits throughout
        #1;
        checks++; if (d_ready !== 2'b00) begin errors++; $display("FAIL bp_wait_ready got=%b exp=00", d_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++; if (d_rsp_valid !== 2'b10) begin errors++; $display("FAIL bp_hold_valid%0d got=%b exp=10", i, d_rsp_valid); end
            checks++; if (d_rsp_rdata !== 32'h2222_2222) begin errors++; $display("FAIL bp_hold_data%0d got=%h exp=22222222", i, d_rsp_rdata); end
            checks++; if (d_ready !== 2'b00) begin errors++; $display("FAIL bp_hold_ready%0d got=%b exp=00", i, d_ready); end
        end
        @(negedge clk);
        d_rsp_ready = 2'b11;
        #1;
        checks++; if ({d_rsp_valid, d_ready} !== 4'b1000) begin errors++; $display("FAIL bp_handshake got=%b exp=1000", {d_rsp_valid, d_ready}); end
        @(negedge clk);
        #1;
        checks++; if (d_ready !== 2'b01) begin errors++; $display("FAIL bp_next_grant got=%b exp=01", d_ready); end
        d_valid = 2'b00;
    endtask

    task automatic test_reset_rd_wait();
        apply_reset();
        d_rsp_ready = 2'b11;
        d_valid = 2'b01; d_we = 2'b00; d_addr[0] = 5'd1;
        #1;
        checks++; if (d_ready !== 2'b01) begin errors++; $display("FAIL rstw_grant got=%b exp=01", d_ready); end
        @(negedge clk);
        d_valid = 2'b00;
        rst = 1'b1;
        #1;
        checks++; if (d_busy !== 1'b1) begin errors++; $display("FAIL rstw_in_rd_wait got=%b exp=1", d_busy); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({d_busy, d_rsp_valid} !== 3'b000) begin errors++; $display("FAIL rstw_dropped got=%b exp=000", {d_busy, d_rsp_valid}); end
        d_valid = 2'b11; d_we = 2'b11; d_addr[0] = 5'd7; d_addr[1] = 5'd8;
        d_wdata[0] = 32'h7777_7777; d_wdata[1] = 32'h8888_8888;
        #1;
        checks++; if (d_ready !== 2'b01) begin errors++; $display("FAIL rstw_ptr_zero got=%b exp=01", d_ready); end
        checks++; if (d_rf_addr !== 5'd7) begin errors++; $display("FAIL rstw_addr got=%0d exp=7", d_rf_addr); end
        @(negedge clk);
        d_valid = 2'b00;
        #1;
        checks++; if (d_rsp_valid !== 2'b01) begin errors++; $display("FAIL rstw_ack got=%b exp=01", d_rsp_valid); end
    endtask

    task automatic test_wrap();
        apply_reset();
        q_rsp_ready = 4'hF;
        q_we = 4'hF; q_addr[3] = 5'd3; q_addr[1] = 5'd1;
        q_wdata[3] = 32'h3333_3333; q_wdata[1] = 32'h0101_0101;
        q_valid = 4'b1000;
        #1;
        checks++; if (q_ready !== 4'b1000) begin errors++; $display("FAIL wrap_grant3 got=%b exp=1000", q_ready); end
        checks++; if ({q_rf_we, q_rf_addr} !== {1'b1, 5'd3}) begin errors++; $display("FAIL wrap_wr3 got=%b/%0d exp=1/3", q_rf_we, q_rf_addr); end
        @(negedge clk);
        q_valid = 4'b1010;
        #1;
        checks++; if ({q_rsp_valid, q_ready} !== 8'b1000_0000) begin errors++; $display("FAIL wrap_ack3 got=%b exp=10000000", {q_rsp_valid, q_ready}); end
        @(negedge clk);
        #1;
        checks++; if (q_ready !== 4'b0010) begin errors++; $display("FAIL wrap_grant1 got=%b exp=0010", q_ready); end
        checks++; if (q_rf_addr !== 5'd1) begin errors++; $display("FAIL wrap_addr1 got=%0d exp=1", q_rf_addr); end
        @(negedge clk);
        q_valid = 4'b1000;
        #1;
        checks++; if (q_rsp_valid !== 4'b0010) begin errors++; $display("FAIL wrap_ack1 got=%b exp=0010", q_rsp_valid); end
        @(negedge clk);
        #1;
        checks++; if (q_ready !== 4'b1000) begin errors++; $display("FAIL wrap_grant3b got=%b exp=1000", q_ready); end
        q_valid = 4'b0000;
    endtask

    // ---------------- sequencing and report ----------------
    initial begin
        clear_inputs();
        test_reset();
        test_write_read();
        test_x0();
        test_round_robin();
        test_backpressure();
        test_reset_rd_wait();
        test_wrap();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
